// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and its upstream conditioners.
// Light codes, lane index map and the per-lane call state type.
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN     = 2'b00;
  localparam logic [1:0] LIGHT_RED       = 2'b10;
  localparam logic [1:0] LIGHT_FLASH_YEL = 2'b11;

  localparam int LANE_N      = 0;
  localparam int LANE_S      = 1;
  localparam int LANE_E      = 2;
  localparam int LANE_W      = 3;
  localparam int LANE_N_LEFT = 4;
  localparam int LANE_S_LEFT = 5;
  localparam int LANE_E_LEFT = 6;
  localparam int LANE_W_LEFT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    CALLED  = 2'd2,
    SERVING = 2'd3
  } lane_state_t;

  // Only a solid green counts as service; flashing yellow and the illegal 01 do not.
  function automatic logic is_green(input logic [1:0] light);
    return light == LIGHT_GREEN;
  endfunction

endpackage

// File: rtl/vehicle_demand_latch_demand_lane.sv
// One approach lane: 2-flop sensor synchroniser, debounce, latched call held
// until a solid green has been shown for SERVE_CYCLES consecutive cycles.
module demand_lane
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int SERVE_CYCLES    = 2,
  parameter int STARVE_CYCLES   = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sensor_raw,
  input  logic [1:0] i_light,
  output logic       o_demand,
  output logic       o_starve
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SERVE_CYCLES + 1);
  localparam int WW = $clog2(STARVE_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SRV_MAX  = SW'(SERVE_CYCLES);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [SW-1:0] SRV_ONE  = SW'(1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  logic          r_s1, r_s2;
  lane_state_t   r_state, w_state_nxt;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt, w_dcnt_inc;
  logic [SW-1:0] r_scnt, w_scnt_nxt, w_scnt_inc;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic          w_green, w_qual;

  assign w_green    = is_green(i_light);
  assign w_qual     = r_s2 && !w_green;
  assign w_dcnt_inc = r_dcnt + DEB_ONE;
  assign w_scnt_inc = r_scnt + SRV_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE;
      r_dcnt  <= '0;
      r_scnt  <= '0;
      r_wait  <= '0;
    end else begin
      r_s1    <= i_sensor_raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_scnt  <= w_scnt_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_scnt_nxt  = r_scnt;
    w_wait_nxt  = r_wait;
    unique case (r_state)
      IDLE: begin
        // A vehicle seen under green just proceeds; no call is raised.
        if (w_qual) begin
          if (DEB_MAX == DEB_ONE) begin
            w_state_nxt = CALLED;
            w_wait_nxt  = '0;
          end else begin
            w_state_nxt = ARMING;
            w_dcnt_nxt  = DEB_ONE;
          end
        end
      end
      ARMING: begin
        if (w_qual) begin
          if (w_dcnt_inc == DEB_MAX) begin
            w_state_nxt = CALLED;
            w_dcnt_nxt  = '0;
            w_wait_nxt  = '0;
          end else begin
            w_dcnt_nxt = w_dcnt_inc;
          end
        end else begin
          w_state_nxt = IDLE;
          w_dcnt_nxt  = '0;
        end
      end
      CALLED: begin
        if (w_green) begin
          w_wait_nxt = '0;
          if (SRV_MAX == SRV_ONE) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SERVING;
            w_scnt_nxt  = SRV_ONE;
          end
        end else if (r_wait != WAIT_MAX) begin
          w_wait_nxt = r_wait + WAIT_ONE;
        end
      end
      SERVING: begin
        if (w_green) begin
          if (w_scnt_inc == SRV_MAX) begin
            w_state_nxt = IDLE;
            w_scnt_nxt  = '0;
          end else begin
            w_scnt_nxt = w_scnt_inc;
          end
        end else begin
          // Green was too short to count as service: back to waiting, clock restarts.
          w_state_nxt = CALLED;
          w_scnt_nxt  = '0;
          w_wait_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_dcnt_nxt  = '0;
        w_scnt_nxt  = '0;
        w_wait_nxt  = '0;
      end
    endcase
  end

  assign o_demand = (r_state == CALLED) || (r_state == SERVING);
  assign o_starve = (r_state == CALLED) && (r_wait == WAIT_MAX);

endmodule

// File: rtl/vehicle_demand_latch.sv
// Loop-detector conditioner for the four-way controller: one independent
// demand_lane per approach, plus an any-call summary for the controller.
module vehicle_demand_latch
  import traffic_pkg::*;
#(
  parameter int N_LANES         = 8,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int SERVE_CYCLES    = 2,
  parameter int STARVE_CYCLES   = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_LANES-1:0]   i_sensor_raw,
  input  logic [2*N_LANES-1:0] i_lane_light,
  output logic [N_LANES-1:0]   o_demand,
  output logic [N_LANES-1:0]   o_starve,
  output logic                 o_any_demand
);

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    demand_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SERVE_CYCLES    (SERVE_CYCLES),
      .STARVE_CYCLES   (STARVE_CYCLES)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .i_sensor_raw (i_sensor_raw[gi]),
      .i_light      (i_lane_light[2*gi +: 2]),
      .o_demand     (o_demand[gi]),
      .o_starve     (o_starve[gi])
    );
  end

  // Built from registered per-lane decodes only, so no input-to-output path.
  assign o_any_demand = |o_demand;

endmodule
